// File: rtl/iob_regfile_sp.sv
// -----------------------------------------------------------------------------
// iob_regfile_sp
//
// Purpose:
//   Single-port register file with 2**ADDR_W entries of DATA_W bits each.
//   - There is one shared read/write address.
//   - Writes are synchronous.
//   - Reads are asynchronous, so d_o follows addr_i combinationally.
//   - A write becomes visible on d_o right after the writing edge.
//   - Before the edge, d_o shows the old contents. There is no bypass from d_i.
//   - Reset is synchronous and active-high. It clears every entry in one edge
//     and takes priority over a simultaneous write.
//   - cke_i = 0 freezes all storage, but reset still acts.
//
// Configuration macro:
//   IOB_REGFILE_SP_R0_ZERO_EN
//     - Defined: entry 0 reads as 0 permanently. Writes to address 0 are
//       dropped, and no storage exists for entry 0.
//     - Undefined (default): entry 0 behaves like every other entry.
//
// Parameters:
//   ADDR_W   address width (depth = 2**ADDR_W)
//   DATA_W   entry width
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        synchronous active-high reset (clears all entries)
//   cke_i    in   1        clock enable; 0 holds all entries
//   we_i     in   1        write enable
//   addr_i   in   ADDR_W   shared read/write address
//   d_i      in   DATA_W   write data
//   d_o      out  DATA_W   read data of entry addr_i (combinational)
// -----------------------------------------------------------------------------
module iob_regfile_sp #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef IOB_REGFILE_SP_R0_ZERO_EN
  // Entry 0 is hard-wired to zero, so only entries 1..DEPTH-1 are stored.
  // Storage slot k holds architectural entry k+1.
  localparam int NSTORE = DEPTH - 1;
`else
  localparam int NSTORE = DEPTH;
`endif

  logic [DATA_W-1:0] r_mem [NSTORE];

  // w_idx    : storage slot for the current address
  // w_stored : the current address maps to a real storage slot
  logic [ADDR_W-1:0] w_idx;
  logic              w_stored;
  logic              w_wr_en;

`ifdef IOB_REGFILE_SP_R0_ZERO_EN
  assign w_idx    = addr_i - ADDR_W'(1);
  assign w_stored = (addr_i != '0);
`else
  assign w_idx    = addr_i;
  assign w_stored = 1'b1;
`endif

  // A write is qualified by clock enable.
  // Addresses without storage never write.
  assign w_wr_en = cke_i & we_i & w_stored;

  // Reset sits outside the clock-enable qualification,
  // so it clears the array even while cke_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSTORE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_idx] <= d_i;
    end
  end

  // Asynchronous read. There is no path from d_i.
  assign d_o = w_stored ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_iob_regfile_sp.sv
// -----------------------------------------------------------------------------
// tb_iob_regfile_sp
//
// Self-checking bench for iob_regfile_sp with default parameters
// (ADDR_W = 4, DATA_W = 32).
// The bench follows IOB_REGFILE_SP_R0_ZERO_EN when it is defined at compile
// time, so the same file covers both builds.
//
// Flow:
//   1. Directed write / read-back and reset sweeps.
//   2. A table of {inputs, expected d_o} corner-case vectors.
//   3. Randomized traffic checked against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_iob_regfile_sp;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

`ifdef IOB_REGFILE_SP_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst;
  logic              cke;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iob_regfile_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cke_i  (cke),
    .we_i   (we),
    .addr_i (addr),
    .d_i    (din),
    .d_o    (dout)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  //   - One array element per entry.
  //   - Updated from the rules: reset clears everything; otherwise an enabled
  //     write stores d_i, except at address 0 when it is hard-wired.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] model_mem [DEPTH];

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (R0_ZERO && a == 0) return '0;
    return model_mem[a];
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (cke && we) begin
      if (!(R0_ZERO && addr == 0)) model_mem[addr] = din;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  task automatic check(input string name);
    logic [DATA_W-1:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_err++;
      $display("FAIL %s: addr=%0d d_o=%h expected=%h", name, addr, dout, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  //   - Inputs change 1 time unit after a rising edge.
  //   - Outputs are sampled at that same point, well away from the next edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic c, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rst  = r;
    cke  = c;
    we   = w;
    addr = a;
    din  = d;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              rst;
    logic              cke;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;   // d_o at addr after the edge
  } vec_t;

  vec_t vecs[10];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    // Initial reset: every address reads 0 afterwards.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i += 5) begin
      addr = ADDR_W'(i);
      #1;
      exp_q.push_back('0);
      check("reset_state");
    end

    // Write 32+i to every address and check it right after the edge.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b1, ADDR_W'(i), DATA_W'(32 + i));
      cycle();
      exp_q.push_back((R0_ZERO && i == 0) ? '0 : DATA_W'(32 + i));
      check("write_readback");
    end

    // Read sweep with we=0: no corruption.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, ADDR_W'(i), 32'hFFFF_0000);
      #1;
      exp_q.push_back((R0_ZERO && i == 0) ? '0 : DATA_W'(32 + i));
      check("read_sweep");
    end

    // No write-through: the old value is shown before the write edge.
    drive(1'b0, 1'b1, 1'b1, 4'd7, 32'hA5A5_0007);
    #1;
    exp_q.push_back(32'd39);
    check("no_bypass_pre_edge");
    cycle();
    exp_q.push_back(32'hA5A5_0007);
    check("no_bypass_post_edge");

    // Restore entry 7 so the table below starts from a known state.
    drive(1'b0, 1'b1, 1'b1, 4'd7, 32'd39);
    cycle();

    // Corner-case table, applied in order. Each row sees the state left by
    // the rows before it.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd3,  32'h55,        32'd35};         // cke=0 blocks write
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'd3,  32'h99,        32'd35};         // we=0 holds
    vecs[2] = '{1'b1, 1'b1, 1'b1, 4'd5,  32'hDEADBEEF,  32'd0};          // reset beats write
    vecs[3] = '{1'b0, 1'b1, 1'b0, 4'd9,  32'h0,         32'd0};          // cleared elsewhere
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'd15, 32'hFFFFFFFF,  32'hFFFFFFFF};   // top address
    vecs[5] = '{1'b1, 1'b0, 1'b1, 4'd15, 32'h1,         32'd0};          // reset with cke=0
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'd0,  32'h1234,      R0_ZERO ? 32'd0 : 32'h1234};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd1,  32'h1234,      32'h1234};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4'd1,  32'h0,         32'h1234};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 4'd0,  32'h0,         R0_ZERO ? 32'd0 : 32'h1234};

    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rst, vecs[v].cke, vecs[v].we, vecs[v].addr, vecs[v].d);
      cycle();
      drive(1'b0, 1'b1, 1'b0, vecs[v].addr, '0);
      #1;
      exp_q.push_back(vecs[v].exp);
      check($sformatf("vec%0d", v));
    end

    // Repopulate, pulse reset, then sweep for zeros.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b1, ADDR_W'(i), DATA_W'(32 + i));
      cycle();
    end
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, ADDR_W'(i), '0);
      #1;
      exp_q.push_back('0);
      check("reset_sweep");
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, DEPTH - 1)),
            DATA_W'($urandom));
      #1;
      // Before the edge, d_o reflects the stored value only.
      exp_q.push_back(model_read(addr));
      check("rand_pre_edge");
      cycle();
      exp_q.push_back(model_read(addr));
      check("rand_post_edge");
      // Combinational read at an unrelated address.
      addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      #1;
      exp_q.push_back(model_read(addr));
      check("rand_read");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
